pipe_stage_regs: RTL and testbench
==================================

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC, instruction and data words.
REQ-002 SHALL have parameter REG_W, default 5, width of register specifiers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 clears all state).
REQ-005 SHALL have port if_instr  input  DATA_W  fetched instruction.
REQ-006 SHALL have port if_pc4  input  DATA_W  PC+4 of fetched instruction.
REQ-007 SHALL have port ifid_hold  input  1  IF/ID keeps contents.
REQ-008 SHALL have port ifid_flush  input  1  IF/ID loads zero (bubble).
REQ-009 SHALL have port ifid_instr, ifid_pc4  output  DATA_W each  IF/ID contents.
REQ-010 SHALL have port id_ctrl  input  9  {RegWrite,MemToReg,MemRead,MemWrite,RegDst,AluSrc,AluOp[1:0],Branch}.
REQ-011 SHALL have port id_pc4, id_rd1, id_rd2  input  DATA_W each  PC+4, register read data 1/2.
REQ-012 SHALL have port id_imm  input  16  immediate field instr[15:0].
REQ-013 SHALL have port id_rs, id_rt, id_rd  input  REG_W each  instr[25:21], [20:16], [15:11].
REQ-014 SHALL have port idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite, idex_regdst, idex_alusrc, idex_branch  output  1 each; idex_aluop  output  2.
REQ-015 SHALL have port idex_pc4, idex_rd1, idex_rd2  output  DATA_W; idex_imm  output  16; idex_rs, idex_rt, idex_rd  output  REG_W.
REQ-016 SHALL have port ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite  input  1 each  EX-stage control.
REQ-017 SHALL have port ex_alu_result, ex_store_data  input  DATA_W; ex_dest  input  REG_W  RegDst-mux output.
REQ-018 SHALL have port exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite  output  1; exmem_alu_result, exmem_store_data  output  DATA_W; exmem_dest  output  REG_W.

Function
REQ-019 SHALL implement three independent register banks IF/ID, ID/EX, EX/MEM, each with exactly one clock of latency input->output.
REQ-020 SHALL, for IF/ID on rising edge: flush=1 -> load zero to both fields; else hold=1 -> retain; else load if_instr/if_pc4.
REQ-021 SHALL give ifid_flush priority over ifid_hold when both are 1.
REQ-022 SHALL load ID/EX unconditionally every rising edge; control bits map to outputs in id_ctrl bit order of REQ-010 (bit8=RegWrite ... bit0=Branch).
REQ-023 SHALL load EX/MEM unconditionally every rising edge.
REQ-024 SHALL drive all outputs directly from flops; no combinational input->output path.
REQ-025 SHALL pass all data fields unmodified (no extension, truncation or arithmetic).

Reset
REQ-026 SHALL, while reset=0, immediately (without clock) force every output of all three banks to 0, and hold 0 for every edge while asserted.
REQ-027 SHALL give reset priority over flush, hold and load; first edge after reset=1 loads normally.
REQ-028 SHALL, on reset asserted mid-operation, discard in-flight contents; no partial update.

Configuration
REQ-029 SHALL, when macro PIPE_STAGE_REGS_IDEX_FLUSH_EN is defined, add input idex_flush (1 bit); idex_flush=1 on an edge loads all ID/EX control outputs (incl. aluop) with 0 while data fields load normally.
REQ-030 SHALL, when PIPE_STAGE_REGS_IDEX_FLUSH_EN is undefined, omit idex_flush; ID/EX behaves per REQ-022 only.

Verification
REQ-031 Reset: reset=0 mid-cycle with registers nonzero -> all outputs 0 before next edge; remain 0 until reset=1.
REQ-032 IF/ID load/hold: if_instr=0x8C220004, if_pc4=0x4 edge -> ifid_instr=0x8C220004; then hold=1, if_instr=0x0 -> unchanged next edge.
REQ-033 IF/ID flush vs hold: hold=1, flush=1 -> ifid_instr=0, ifid_pc4=0 after edge.
REQ-034 ID/EX: id_ctrl=9'b1_0_0_0_1_0_10_0, id_rd1=20, id_rd2=30, id_rs=2, id_rt=3, id_rd=1 -> next edge idex_regwrite=1, idex_regdst=1, idex_aluop=2'b10, others 0, data fields equal inputs.
REQ-035 EX/MEM: ex_alu_result=0xC, ex_store_data=99, ex_dest=4, ex_memwrite=1 -> all appear one edge later, unchanged.
REQ-036 With PIPE_STAGE_REGS_IDEX_FLUSH_EN: id_ctrl=9'h1FF, idex_flush=1 -> control outputs all 0, idex_rd1 still loads.

Source files
------------

// File: rtl/pipe_stage_regs_if.sv
// Bus bundle for pipe_stage_regs: IF/ID, ID/EX and EX/MEM stage inputs and outputs.
//   master : pipeline datapath side; drives stage inputs and observes register outputs
//   slave  : the stage-register block; consumes stage inputs and drives register outputs
// Optional macro PIPE_STAGE_REGS_IDEX_FLUSH_EN adds idex_flush.
interface pipe_stage_regs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  // IF/ID
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc4;
  logic              ifid_hold;
  logic              ifid_flush;
  logic [DATA_W-1:0] ifid_instr;
  logic [DATA_W-1:0] ifid_pc4;

  // ID/EX
  logic [8:0]        id_ctrl;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [15:0]       id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
`ifdef PIPE_STAGE_REGS_IDEX_FLUSH_EN
  logic              idex_flush;
`endif
  logic              idex_regwrite;
  logic              idex_memtoreg;
  logic              idex_memread;
  logic              idex_memwrite;
  logic              idex_regdst;
  logic              idex_alusrc;
  logic [1:0]        idex_aluop;
  logic              idex_branch;
  logic [DATA_W-1:0] idex_pc4;
  logic [DATA_W-1:0] idex_rd1;
  logic [DATA_W-1:0] idex_rd2;
  logic [15:0]       idex_imm;
  logic [REG_W-1:0]  idex_rs;
  logic [REG_W-1:0]  idex_rt;
  logic [REG_W-1:0]  idex_rd;

  // EX/MEM
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              ex_memread;
  logic              ex_memwrite;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_dest;
  logic              exmem_regwrite;
  logic              exmem_memtoreg;
  logic              exmem_memread;
  logic              exmem_memwrite;
  logic [DATA_W-1:0] exmem_alu_result;
  logic [DATA_W-1:0] exmem_store_data;
  logic [REG_W-1:0]  exmem_dest;

  modport master (
    output if_instr, if_pc4, ifid_hold, ifid_flush,
    output id_ctrl, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
`ifdef PIPE_STAGE_REGS_IDEX_FLUSH_EN
    output idex_flush,
`endif
    output ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
    output ex_alu_result, ex_store_data, ex_dest,
    input  ifid_instr, ifid_pc4,
    input  idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite,
    input  idex_regdst, idex_alusrc, idex_aluop, idex_branch,
    input  idex_pc4, idex_rd1, idex_rd2, idex_imm, idex_rs, idex_rt, idex_rd,
    input  exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite,
    input  exmem_alu_result, exmem_store_data, exmem_dest
  );

  modport slave (
    input  if_instr, if_pc4, ifid_hold, ifid_flush,
    input  id_ctrl, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
`ifdef PIPE_STAGE_REGS_IDEX_FLUSH_EN
    input  idex_flush,
`endif
    input  ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
    input  ex_alu_result, ex_store_data, ex_dest,
    output ifid_instr, ifid_pc4,
    output idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite,
    output idex_regdst, idex_alusrc, idex_aluop, idex_branch,
    output idex_pc4, idex_rd1, idex_rd2, idex_imm, idex_rs, idex_rt, idex_rd,
    output exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite,
    output exmem_alu_result, exmem_store_data, exmem_dest
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// Pipeline stage registers IF/ID, ID/EX, EX/MEM; one clock of latency each.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears every bank
//   bus   : pipe_stage_regs_if.slave carrying all stage inputs/outputs
// Optional macro PIPE_STAGE_REGS_IDEX_FLUSH_EN: idex_flush zeroes the ID/EX control bits.
module pipe_stage_regs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_regs_if.slave bus
);
  localparam int unsigned IDEX_CTRL_W  = 9;
  localparam int unsigned EXMEM_CTRL_W = 4;

  logic [DATA_W-1:0]       ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0]       ifid_pc4_q, ifid_pc4_d;

  logic [IDEX_CTRL_W-1:0]  idex_ctrl_q, idex_ctrl_d;
  logic [DATA_W-1:0]       idex_pc4_q, idex_pc4_d;
  logic [DATA_W-1:0]       idex_rd1_q, idex_rd1_d;
  logic [DATA_W-1:0]       idex_rd2_q, idex_rd2_d;
  logic [15:0]             idex_imm_q, idex_imm_d;
  logic [REG_W-1:0]        idex_rs_q, idex_rs_d;
  logic [REG_W-1:0]        idex_rt_q, idex_rt_d;
  logic [REG_W-1:0]        idex_rd_q, idex_rd_d;

  logic [EXMEM_CTRL_W-1:0] exmem_ctrl_q, exmem_ctrl_d;
  logic [DATA_W-1:0]       exmem_alu_q, exmem_alu_d;
  logic [DATA_W-1:0]       exmem_st_q, exmem_st_d;
  logic [REG_W-1:0]        exmem_dest_q, exmem_dest_d;

  // Next-state: IF/ID flush beats hold; ID/EX and EX/MEM load every edge.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (bus.ifid_flush) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
    end else if (!bus.ifid_hold) begin
      ifid_instr_d = bus.if_instr;
      ifid_pc4_d   = bus.if_pc4;
    end

`ifdef PIPE_STAGE_REGS_IDEX_FLUSH_EN
    idex_ctrl_d = bus.idex_flush ? '0 : bus.id_ctrl;
`else
    idex_ctrl_d = bus.id_ctrl;
`endif
    idex_pc4_d = bus.id_pc4;
    idex_rd1_d = bus.id_rd1;
    idex_rd2_d = bus.id_rd2;
    idex_imm_d = bus.id_imm;
    idex_rs_d  = bus.id_rs;
    idex_rt_d  = bus.id_rt;
    idex_rd_d  = bus.id_rd;

    exmem_ctrl_d = {bus.ex_regwrite, bus.ex_memtoreg, bus.ex_memread, bus.ex_memwrite};
    exmem_alu_d  = bus.ex_alu_result;
    exmem_st_d   = bus.ex_store_data;
    exmem_dest_d = bus.ex_dest;
  end

  // State registers; reset clears every bank without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      idex_ctrl_q  <= '0;
      idex_pc4_q   <= '0;
      idex_rd1_q   <= '0;
      idex_rd2_q   <= '0;
      idex_imm_q   <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      exmem_ctrl_q <= '0;
      exmem_alu_q  <= '0;
      exmem_st_q   <= '0;
      exmem_dest_q <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_pc4_q   <= idex_pc4_d;
      idex_rd1_q   <= idex_rd1_d;
      idex_rd2_q   <= idex_rd2_d;
      idex_imm_q   <= idex_imm_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_alu_q  <= exmem_alu_d;
      exmem_st_q   <= exmem_st_d;
      exmem_dest_q <= exmem_dest_d;
    end
  end

  // Outputs straight from flops; control bit order {RegWrite..AluOp[1:0],Branch}.
  assign bus.ifid_instr       = ifid_instr_q;
  assign bus.ifid_pc4         = ifid_pc4_q;
  assign bus.idex_regwrite    = idex_ctrl_q[8];
  assign bus.idex_memtoreg    = idex_ctrl_q[7];
  assign bus.idex_memread     = idex_ctrl_q[6];
  assign bus.idex_memwrite    = idex_ctrl_q[5];
  assign bus.idex_regdst      = idex_ctrl_q[4];
  assign bus.idex_alusrc      = idex_ctrl_q[3];
  assign bus.idex_aluop       = idex_ctrl_q[2:1];
  assign bus.idex_branch      = idex_ctrl_q[0];
  assign bus.idex_pc4         = idex_pc4_q;
  assign bus.idex_rd1         = idex_rd1_q;
  assign bus.idex_rd2         = idex_rd2_q;
  assign bus.idex_imm         = idex_imm_q;
  assign bus.idex_rs          = idex_rs_q;
  assign bus.idex_rt          = idex_rt_q;
  assign bus.idex_rd          = idex_rd_q;
  assign bus.exmem_regwrite   = exmem_ctrl_q[3];
  assign bus.exmem_memtoreg   = exmem_ctrl_q[2];
  assign bus.exmem_memread    = exmem_ctrl_q[1];
  assign bus.exmem_memwrite   = exmem_ctrl_q[0];
  assign bus.exmem_alu_result = exmem_alu_q;
  assign bus.exmem_store_data = exmem_st_q;
  assign bus.exmem_dest       = exmem_dest_q;
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs.
module tb_pipe_stage_regs;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pipe_stage_regs_if #(.DATA_W(32), .REG_W(5)) bus ();

  pipe_stage_regs #(.DATA_W(32), .REG_W(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [8:0]  idex_ctrl  = {bus.idex_regwrite, bus.idex_memtoreg, bus.idex_memread,
                            bus.idex_memwrite, bus.idex_regdst, bus.idex_alusrc,
                            bus.idex_aluop, bus.idex_branch};
  wire [3:0]  exmem_ctrl = {bus.exmem_regwrite, bus.exmem_memtoreg,
                            bus.exmem_memread, bus.exmem_memwrite};
  wire [14:0] idex_regs  = {bus.idex_rs, bus.idex_rt, bus.idex_rd};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [8:0] ctrl, input logic [31:0] pc4, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [15:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.id_ctrl = ctrl; bus.id_pc4 = pc4; bus.id_rd1 = rd1; bus.id_rd2 = rd2;
    bus.id_imm  = imm;  bus.id_rs  = rs;  bus.id_rt  = rt;  bus.id_rd  = rd;
  endtask

  task automatic drive_ex(input logic [3:0] ctrl, input logic [31:0] alu,
                          input logic [31:0] st, input logic [4:0] dest);
    {bus.ex_regwrite, bus.ex_memtoreg, bus.ex_memread, bus.ex_memwrite} = ctrl;
    bus.ex_alu_result = alu; bus.ex_store_data = st; bus.ex_dest = dest;
  endtask

  initial begin
    reset          = 1'b0;
    bus.if_instr   = 32'hDEADBEEF;
    bus.if_pc4     = 32'h0000_0100;
    bus.ifid_hold  = 1'b0;
    bus.ifid_flush = 1'b0;
`ifdef PIPE_STAGE_REGS_IDEX_FLUSH_EN
    bus.idex_flush = 1'b0;
`endif
    drive_id(9'h1FF, 32'h11, 32'h22, 32'h33, 16'hFFFF, 5'd31, 5'd31, 5'd31);
    drive_ex(4'hF, 32'h44, 32'h55, 5'd31);

    // Reset held across an edge with nonzero inputs
    tick();
    chk("rst_ifid_instr", bus.ifid_instr, 32'h0);
    chk("rst_ifid_pc4", bus.ifid_pc4, 32'h0);
    chk("rst_idex_ctrl", 32'(idex_ctrl), 32'h0);
    chk("rst_idex_rd1", bus.idex_rd1, 32'h0);
    chk("rst_idex_imm", 32'(bus.idex_imm), 32'h0);
    chk("rst_exmem_ctrl", 32'(exmem_ctrl), 32'h0);
    chk("rst_exmem_alu", bus.exmem_alu_result, 32'h0);

    // First edge after release loads; IF/ID, ID/EX, EX/MEM vectors
    @(negedge clk);
    reset        = 1'b1;
    bus.if_instr = 32'h8C220004;
    bus.if_pc4   = 32'h0000_0004;
    drive_id(9'b1_0_0_0_1_0_10_0, 32'h8, 32'd20, 32'd30, 16'h0004, 5'd2, 5'd3, 5'd1);
    drive_ex(4'b0001, 32'h0000_000C, 32'd99, 5'd4);
    tick();
    chk("load_ifid_instr", bus.ifid_instr, 32'h8C220004);
    chk("load_ifid_pc4", bus.ifid_pc4, 32'h4);
    chk("idex_ctrl_v1", 32'(idex_ctrl), 32'h114);
    chk("idex_aluop_v1", 32'(bus.idex_aluop), 32'h2);
    chk("idex_pc4_v1", bus.idex_pc4, 32'h8);
    chk("idex_rd1_v1", bus.idex_rd1, 32'd20);
    chk("idex_rd2_v1", bus.idex_rd2, 32'd30);
    chk("idex_imm_v1", 32'(bus.idex_imm), 32'h4);
    chk("idex_regs_v1", 32'(idex_regs), 32'h0861);
    chk("exmem_ctrl_v1", 32'(exmem_ctrl), 32'h1);
    chk("exmem_alu_v1", bus.exmem_alu_result, 32'hC);
    chk("exmem_st_v1", bus.exmem_store_data, 32'd99);
    chk("exmem_dest_v1", 32'(bus.exmem_dest), 32'd4);

    // Hold IF/ID; second ID/EX and EX/MEM patterns
    @(negedge clk);
    bus.ifid_hold = 1'b1;
    bus.if_instr  = 32'h0;
    bus.if_pc4    = 32'h0;
    drive_id(9'b0_1_1_0_0_1_01_1, 32'hFFFF_FFFC, 32'hAAAA5555, 32'h8000_0001, 16'h8001,
             5'd31, 5'd0, 5'd16);
    drive_ex(4'b1110, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31);
    tick();
    chk("hold_ifid_instr", bus.ifid_instr, 32'h8C220004);
    chk("hold_ifid_pc4", bus.ifid_pc4, 32'h4);
    chk("idex_ctrl_v2", 32'(idex_ctrl), 32'h0CB);
    chk("idex_pc4_v2", bus.idex_pc4, 32'hFFFF_FFFC);
    chk("idex_rd1_v2", bus.idex_rd1, 32'hAAAA5555);
    chk("idex_rd2_v2", bus.idex_rd2, 32'h8000_0001);
    chk("idex_imm_v2", 32'(bus.idex_imm), 32'h8001);
    chk("idex_regs_v2", 32'(idex_regs), 32'h7C10);
    chk("exmem_ctrl_v2", 32'(exmem_ctrl), 32'hE);
    chk("exmem_alu_v2", bus.exmem_alu_result, 32'hFFFF_FFFF);
    chk("exmem_st_v2", bus.exmem_store_data, 32'h8000_0000);
    chk("exmem_dest_v2", 32'(bus.exmem_dest), 32'd31);

    // Release hold
    @(negedge clk);
    bus.ifid_hold = 1'b0;
    bus.if_instr  = 32'h1234_5678;
    bus.if_pc4    = 32'h0000_0008;
    tick();
    chk("reload_ifid_instr", bus.ifid_instr, 32'h1234_5678);
    chk("reload_ifid_pc4", bus.ifid_pc4, 32'h8);

    // Flush wins over hold
    @(negedge clk);
    bus.ifid_hold  = 1'b1;
    bus.ifid_flush = 1'b1;
    bus.if_instr   = 32'hFFFF_FFFF;
    tick();
    chk("flushhold_ifid_instr", bus.ifid_instr, 32'h0);
    chk("flushhold_ifid_pc4", bus.ifid_pc4, 32'h0);

    // Load after flush, then flush alone
    @(negedge clk);
    bus.ifid_hold  = 1'b0;
    bus.ifid_flush = 1'b0;
    bus.if_instr   = 32'h0000_1111;
    bus.if_pc4     = 32'h0000_000C;
    tick();
    chk("postflush_ifid_instr", bus.ifid_instr, 32'h0000_1111);
    @(negedge clk);
    bus.ifid_flush = 1'b1;
    tick();
    chk("flush_ifid_instr", bus.ifid_instr, 32'h0);
    chk("flush_ifid_pc4", bus.ifid_pc4, 32'h0);

    // Asynchronous reset mid-cycle with nonzero contents
    @(negedge clk);
    bus.ifid_flush = 1'b0;
    bus.if_instr   = 32'hA5A5_A5A5;
    bus.if_pc4     = 32'h0000_0010;
    tick();
    chk("pre_arst_ifid_instr", bus.ifid_instr, 32'hA5A5_A5A5);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ifid_instr", bus.ifid_instr, 32'h0);
    chk("arst_ifid_pc4", bus.ifid_pc4, 32'h0);
    chk("arst_idex_ctrl", 32'(idex_ctrl), 32'h0);
    chk("arst_idex_rd1", bus.idex_rd1, 32'h0);
    chk("arst_idex_regs", 32'(idex_regs), 32'h0);
    chk("arst_exmem_ctrl", 32'(exmem_ctrl), 32'h0);
    chk("arst_exmem_alu", bus.exmem_alu_result, 32'h0);
    chk("arst_exmem_dest", 32'(bus.exmem_dest), 32'h0);
    tick();
    chk("arst_held_ifid", bus.ifid_instr, 32'h0);
    chk("arst_held_idex_rd2", bus.idex_rd2, 32'h0);
    chk("arst_held_exmem_st", bus.exmem_store_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel_ifid_instr", bus.ifid_instr, 32'hA5A5_A5A5);
    chk("rel_idex_rd1", bus.idex_rd1, 32'hAAAA5555);
    chk("rel_exmem_ctrl", 32'(exmem_ctrl), 32'hE);

`ifdef PIPE_STAGE_REGS_IDEX_FLUSH_EN
    // ID/EX bubble: control zeroed, data still loads
    @(negedge clk);
    bus.idex_flush = 1'b1;
    drive_id(9'h1FF, 32'h24, 32'h77, 32'h88, 16'h1234, 5'd5, 5'd6, 5'd7);
    tick();
    chk("idexflush_ctrl", 32'(idex_ctrl), 32'h0);
    chk("idexflush_rd1", bus.idex_rd1, 32'h77);
    chk("idexflush_regs", 32'(idex_regs), 32'h14C7);
    @(negedge clk);
    bus.idex_flush = 1'b0;
    tick();
    chk("idexnoflush_ctrl", 32'(idex_ctrl), 32'h1FF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
